// File: rtl/soc_mem_pkg.sv
// Shared types for the SRAM-backed responders on the core's memory ports.
package soc_mem_pkg;

  // Width of the wait-state down-counter; bounds WaitStates to 0..7.
  localparam int WS_CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } resp_state_e;

  // Attributes of the granted request, carried to the response cycle.
  typedef struct packed {
    logic read;
    logic err;
  } rsp_flags_t;

endpackage

// File: rtl/obi_addr_dec.sv
// Combinational window decode: flags requests outside the SRAM window or with
// no byte enables so the responder can error them without touching the SRAM.
module obi_addr_dec #(
  parameter logic [31:0] BaseAddr = 32'h1000_0000,
  parameter int          SramAw   = 10
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output logic        hit,
  output logic        bad
);

  // Window is 4*2^SramAw bytes; BaseAddr is aligned to it, so a mask compare suffices.
  localparam logic [31:0] WinMask = ~((32'd4 << SramAw) - 32'd1);

  assign hit = ((addr & WinMask) == BaseAddr);
  assign bad = !hit || (be == 4'h0);

endmodule

// File: rtl/obi_sram_responder.sv
// Data-port responder: decodes one SRAM window, inserts WaitStates cycles
// before gnt, strobes a 1-cycle-latency SRAM and returns rvalid one cycle
// after every grant.
module obi_sram_responder
  import soc_mem_pkg::*;
#(
  parameter int          SramAw     = 10,
  parameter logic [31:0] BaseAddr   = 32'h1000_0000,
  parameter int          WaitStates = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [SramAw-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  if (WaitStates < 0 || WaitStates > (1 << WS_CNT_W) - 1) begin : g_ws_range
    $error("obi_sram_responder: WaitStates must be in 0..7");
  end

  // The IDLE cycle that sees req counts as the first wait cycle.
  localparam logic [WS_CNT_W-1:0] WsLoad =
    (WaitStates > 0) ? WS_CNT_W'(WaitStates - 1) : '0;

  resp_state_e         state_q, state_d;
  logic [WS_CNT_W-1:0] cnt_q, cnt_d;
  rsp_flags_t          flags_q;
  logic                rvalid_q;
  logic                gnt;
  logic                hit;
  logic                bad;

  obi_addr_dec #(
    .BaseAddr(BaseAddr),
    .SramAw  (SramAw)
  ) u_dec (
    .addr(data_addr_i),
    .be  (data_be_i),
    .hit (hit),
    .bad (bad)
  );

  // Next-state and grant: bad requests skip the wait states entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (bad || WaitStates == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = WsLoad;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          // Requester withdrew before grant: abandon without an access.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          gnt     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing is granted or strobed while reset is held.
  assign data_gnt_o   = gnt && !rst_i;
  assign sram_en_o    = data_gnt_o && !bad;
  assign sram_we_o    = sram_en_o && data_we_i;
  assign sram_be_o    = data_we_i ? data_be_i : 4'hF;
  assign sram_addr_o  = data_addr_i[SramAw+1:2];
  assign sram_wdata_o = data_wdata_i;

  // State, wait counter and the response pipeline stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rvalid_q     <= data_gnt_o;
      flags_q.read <= data_gnt_o && !data_we_i;
      flags_q.err  <= data_gnt_o && bad;
    end
  end

  // Flags are zero outside a response cycle, so rdata idles at zero too.
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = flags_q.err;
  assign data_rdata_o  = (flags_q.read && !flags_q.err) ? sram_rdata_i : 32'h0;

endmodule
